// File: rtl/alarm_clock_pkg.sv
// Shared time-of-day constants and FSM encoding for the alarm clock blocks.
// The alarm comparator uses the same field widths and limits.
package alarm_clock_pkg;

  localparam int unsigned TIME_W = 8;

  typedef logic [TIME_W-1:0] time_field_t;

  localparam time_field_t HR_MAX  = 8'd23;
  localparam time_field_t MIN_MAX = 8'd59;
  localparam time_field_t SEC_MAX = 8'd59;

  typedef enum logic [1:0] {
    RUN = 2'b00,
    SET = 2'b01
  } tk_state_t;

  // Increment with wrap by compare against the field maximum.
  function automatic time_field_t wrap_inc(time_field_t v, time_field_t max_v);
    return (v == max_v) ? '0 : v + time_field_t'(1);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one history register, rise = level & ~prev.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b0;
    else      prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/time_keeper.sv
// 24-hour sec/min/hr counter driven by a one-second prescaler, with a
// frozen set mode where button rising edges advance hours and minutes.
module time_keeper
  import alarm_clock_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_time,
  input  logic       inc_hr,
  input  logic       inc_min,
  output logic [7:0] hr,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       sec_tick,
  output logic       min_tick
);

  localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);

  tk_state_t   state, state_n;
  logic [PW-1:0] presc, presc_n;
  time_field_t hr_n, min_n, sec_n;
  logic        sec_tick_n, min_tick_n;
  logic        hr_rise, min_rise;

  rise_detect u_rise_hr (
    .clk   (clk),
    .rst   (rst),
    .level (inc_hr),
    .rise  (hr_rise)
  );

  rise_detect u_rise_min (
    .clk   (clk),
    .rst   (rst),
    .level (inc_min),
    .rise  (min_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      presc    <= '0;
      hr       <= '0;
      min      <= '0;
      sec      <= '0;
      sec_tick <= 1'b0;
      min_tick <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      hr       <= hr_n;
      min      <= min_n;
      sec      <= sec_n;
      sec_tick <= sec_tick_n;
      min_tick <= min_tick_n;
    end
  end

  always_comb begin
    state_n    = state;
    presc_n    = presc;
    hr_n       = hr;
    min_n      = min;
    sec_n      = sec;
    sec_tick_n = 1'b0;
    min_tick_n = 1'b0;
    unique case (state)
      RUN: begin
        // Entering set mode takes priority over a coincident rollover.
        if (set_time) begin
          state_n = SET;
          presc_n = '0;
          sec_n   = '0;
        end else if (presc == PRE_MAX) begin
          presc_n    = '0;
          sec_tick_n = 1'b1;
          sec_n      = wrap_inc(sec, SEC_MAX);
          if (sec == SEC_MAX) begin
            min_tick_n = 1'b1;
            min_n      = wrap_inc(min, MIN_MAX);
            if (min == MIN_MAX) hr_n = wrap_inc(hr, HR_MAX);
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      SET: begin
        presc_n = '0;
        sec_n   = '0;
        if (!set_time) state_n = RUN;
        if (hr_rise)  hr_n  = wrap_inc(hr, HR_MAX);
        if (min_rise) min_n = wrap_inc(min, MIN_MAX);
      end
      default: state_n = RUN;
    endcase
  end

endmodule
